// File: rtl/uart_lite_pkg.sv
// Shared definitions for the uart_lite peripheral: register map,
// STATUS bit positions, FSM encodings and the divisor floor.
package uart_lite_pkg;

  localparam logic [7:0] ADDR_TXDATA = 8'h00;
  localparam logic [7:0] ADDR_RXDATA = 8'h04;
  localparam logic [7:0] ADDR_STATUS = 8'h08;
  localparam logic [7:0] ADDR_BAUD   = 8'h0C;
  localparam logic [7:0] ADDR_CTRL   = 8'h10;

  localparam int ST_RX_VALID  = 0;
  localparam int ST_TX_FULL   = 1;
  localparam int ST_TX_BUSY   = 2;
  localparam int ST_RX_OVR    = 3;
  localparam int ST_FRAME_ERR = 4;

  localparam logic [15:0] MIN_DIV = 16'd3;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  function automatic logic [15:0] eff_div(
    input logic [15:0] d
  );
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

endpackage

// File: rtl/uart_lite_rx.sv
// uart_lite receiver: rx synchroniser, 8N1 deserialiser FSM and
// its bit counter. Emits one-cycle push / frame_err pulses.
module uart_lite_rx
  import uart_lite_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_rx,
  input  logic [15:0] i_div,
  output logic [7:0]  o_byte,
  output logic        o_push,
  output logic        o_frame_err
);

  logic        r_sync1;
  logic        r_sync2;
  logic        r_prev;
  rx_state_e   r_state;
  rx_state_e   w_state_nx;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nx;
  logic [2:0]  r_bit;
  logic [2:0]  w_bit_nx;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_nx;
  logic        w_tick;

  assign w_tick = (r_cnt == 16'd0);
  assign o_byte = r_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_bit   <= w_bit_nx;
      r_shift <= w_shift_nx;
    end
  end

  // Counter runs half a bit in START so later samples land mid-bit
  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_bit_nx    = r_bit;
    w_shift_nx  = r_shift;
    o_push      = 1'b0;
    o_frame_err = 1'b0;
    unique case (r_state)
      RX_IDLE: begin
        if (r_prev && !r_sync2) begin
          w_state_nx = RX_START;
          w_cnt_nx   = {1'b0, i_div[15:1]};
        end
      end
      RX_START: begin
        if (!w_tick) begin
          w_cnt_nx = r_cnt - 16'd1;
        end else if (!r_sync2) begin
          w_state_nx = RX_DATA;
          w_cnt_nx   = i_div;
          w_bit_nx   = '0;
        end else begin
          w_state_nx = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (!w_tick) begin
          w_cnt_nx = r_cnt - 16'd1;
        end else begin
          w_shift_nx = {r_sync2, r_shift[7:1]};
          w_cnt_nx   = i_div;
          w_bit_nx   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_nx = RX_STOP;
        end
      end
      RX_STOP: begin
        if (!w_tick) begin
          w_cnt_nx = r_cnt - 16'd1;
        end else begin
          o_push      = r_sync2;
          o_frame_err = !r_sync2;
          w_state_nx  = RX_IDLE;
        end
      end
      default: w_state_nx = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_lite_periph.sv
// Memory-mapped 8N1 UART slave: register file, TX FSM, RX storage.
// UART_LITE_RX_FIFO_EN selects a 4-deep RX FIFO over a single register.
module uart_lite_periph
  import uart_lite_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEFAULT_DIV = 433
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs_i,
  input  logic                  we_i,
  input  logic [7:0]            addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  ready_o,
  output logic                  tx_o,
  input  logic                  rx_i,
  output logic                  irq_o
);

  logic [15:0] r_baud;
  logic [1:0]  r_ctrl;
  logic [7:0]  r_thr;
  logic        r_tx_full;
  logic        r_tx_o;
  tx_state_e   r_tx_state;
  tx_state_e   w_tx_state_nx;
  logic [15:0] r_tx_cnt;
  logic [15:0] w_tx_cnt_nx;
  logic [7:0]  r_tx_shift;
  logic [7:0]  w_tx_shift_nx;
  logic [2:0]  r_tx_bit;
  logic [2:0]  w_tx_bit_nx;
  logic        w_tx_load;
  logic        w_tx_o_nx;
  logic        w_tx_busy;
  logic        r_rx_ovr;
  logic        r_frame_err;
  logic        r_irq;

  logic        w_rd;
  logic        w_wr;
  logic        w_wr_thr;
  logic        w_wr_st;
  logic        w_rd_rx;
  logic [15:0] w_div;
  logic [7:0]  w_rx_byte_in;
  logic        w_rx_push;
  logic        w_rx_ferr;
  logic        w_rx_valid;
  logic        w_rx_pop;
  logic        w_rx_accept;
  logic        w_rx_drop;
  logic [7:0]  w_rx_data;
  logic [2:0]  w_rx_lvl;
  logic [7:0]  w_status;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic        w_unused;

  assign w_rd     = cs_i & !we_i;
  assign w_wr     = cs_i & we_i;
  assign w_wr_thr = w_wr & (addr_i == ADDR_TXDATA);
  assign w_wr_st  = w_wr & (addr_i == ADDR_STATUS);
  assign w_rd_rx  = w_rd & (addr_i == ADDR_RXDATA);
  assign w_div    = eff_div(r_baud);
  assign w_unused = ^wdata_i[DATA_WIDTH-1:16];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud <= 16'(DEFAULT_DIV);
      r_ctrl <= '0;
    end else if (w_wr) begin
      if (addr_i == ADDR_BAUD) r_baud <= wdata_i[15:0];
      if (addr_i == ADDR_CTRL) r_ctrl <= wdata_i[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_thr     <= '0;
      r_tx_full <= 1'b0;
    end else if (w_tx_load) begin
      r_tx_full <= 1'b0;
    end else if (w_wr_thr && !r_tx_full) begin
      r_thr     <= wdata_i[7:0];
      r_tx_full <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_shift <= '0;
      r_tx_bit   <= '0;
      r_tx_o     <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nx;
      r_tx_cnt   <= w_tx_cnt_nx;
      r_tx_shift <= w_tx_shift_nx;
      r_tx_bit   <= w_tx_bit_nx;
      r_tx_o     <= w_tx_o_nx;
    end
  end

  // tx_o is registered from next-state so the pin never glitches
  always_comb begin
    w_tx_state_nx = r_tx_state;
    w_tx_cnt_nx   = r_tx_cnt;
    w_tx_shift_nx = r_tx_shift;
    w_tx_bit_nx   = r_tx_bit;
    w_tx_load     = 1'b0;
    unique case (r_tx_state)
      TX_IDLE: begin
        w_tx_load = r_tx_full;
      end
      TX_START: begin
        if (r_tx_cnt != 16'd0) begin
          w_tx_cnt_nx = r_tx_cnt - 16'd1;
        end else begin
          w_tx_state_nx = TX_DATA;
          w_tx_cnt_nx   = w_div;
          w_tx_bit_nx   = '0;
        end
      end
      TX_DATA: begin
        if (r_tx_cnt != 16'd0) begin
          w_tx_cnt_nx = r_tx_cnt - 16'd1;
        end else begin
          w_tx_shift_nx = {1'b0, r_tx_shift[7:1]};
          w_tx_cnt_nx   = w_div;
          w_tx_bit_nx   = r_tx_bit + 3'd1;
          if (r_tx_bit == 3'd7) w_tx_state_nx = TX_STOP;
        end
      end
      TX_STOP: begin
        if (r_tx_cnt != 16'd0) begin
          w_tx_cnt_nx = r_tx_cnt - 16'd1;
        end else if (r_tx_full) begin
          w_tx_load = 1'b1;
        end else begin
          w_tx_state_nx = TX_IDLE;
        end
      end
      default: w_tx_state_nx = TX_IDLE;
    endcase
    if (w_tx_load) begin
      w_tx_state_nx = TX_START;
      w_tx_cnt_nx   = w_div;
      w_tx_shift_nx = r_thr;
    end
    unique case (w_tx_state_nx)
      TX_START: w_tx_o_nx = 1'b0;
      TX_DATA:  w_tx_o_nx = w_tx_shift_nx[0];
      default:  w_tx_o_nx = 1'b1;
    endcase
  end

  assign w_tx_busy = (r_tx_state != TX_IDLE);
  assign tx_o      = r_tx_o;

  uart_lite_rx u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rx        (rx_i),
    .i_div       (w_div),
    .o_byte      (w_rx_byte_in),
    .o_push      (w_rx_push),
    .o_frame_err (w_rx_ferr)
  );

`ifdef UART_LITE_RX_FIFO_EN
  logic [7:0] r_fifo [4];
  logic [1:0] r_wp;
  logic [1:0] r_rp;
  logic [2:0] r_cnt;

  assign w_rx_valid  = (r_cnt != 3'd0);
  assign w_rx_pop    = w_rd_rx & w_rx_valid;
  assign w_rx_accept = w_rx_push & ((r_cnt != 3'd4) | w_rx_pop);
  assign w_rx_drop   = w_rx_push & !w_rx_accept;
  assign w_rx_data   = r_fifo[r_rp];
  assign w_rx_lvl    = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_fifo[i] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_rx_accept) begin
        r_fifo[r_wp] <= w_rx_byte_in;
        r_wp         <= r_wp + 2'd1;
      end
      if (w_rx_pop) r_rp <= r_rp + 2'd1;
      r_cnt <= r_cnt + {2'b0, w_rx_accept} - {2'b0, w_rx_pop};
    end
  end
`else
  logic [7:0] r_rx_data;
  logic       r_rx_valid;

  assign w_rx_valid  = r_rx_valid;
  assign w_rx_pop    = w_rd_rx & r_rx_valid;
  assign w_rx_accept = w_rx_push & (!r_rx_valid | w_rx_pop);
  assign w_rx_drop   = w_rx_push & !w_rx_accept;
  assign w_rx_data   = r_rx_data;
  assign w_rx_lvl    = 3'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else if (w_rx_accept) begin
      r_rx_data  <= w_rx_byte_in;
      r_rx_valid <= 1'b1;
    end else if (w_rx_pop) begin
      r_rx_valid <= 1'b0;
    end
  end
`endif

  // Sticky error flags: a new event wins over a same-cycle W1C
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_ovr    <= 1'b0;
      r_frame_err <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      if (w_rx_drop) r_rx_ovr <= 1'b1;
      else if (w_wr_st && wdata_i[ST_RX_OVR]) r_rx_ovr <= 1'b0;
      if (w_rx_ferr) r_frame_err <= 1'b1;
      else if (w_wr_st && wdata_i[ST_FRAME_ERR]) r_frame_err <= 1'b0;
      r_irq <= (w_rx_valid & r_ctrl[0]) | (!r_tx_full & r_ctrl[1]);
    end
  end

  assign w_status = {w_rx_lvl, r_frame_err, r_rx_ovr,
                     w_tx_busy, r_tx_full, w_rx_valid};

  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      unique case (1'b1)
        (addr_i == ADDR_RXDATA):
          w_rdata = w_rx_valid ? DATA_WIDTH'(w_rx_data) : '0;
        (addr_i == ADDR_STATUS): w_rdata = DATA_WIDTH'(w_status);
        (addr_i == ADDR_BAUD):   w_rdata = DATA_WIDTH'(r_baud);
        (addr_i == ADDR_CTRL):   w_rdata = DATA_WIDTH'(r_ctrl);
        default:                 w_rdata = '0;
      endcase
    end
  end

  assign rdata_o = w_rdata;
  assign ready_o = cs_i;
  assign irq_o   = r_irq;

endmodule
